// File: rtl/updown_pkg.sv
// Shared types and constants for the two-requester up/down counter scheduler.
package updown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_PRESCALE = 1;

    // Round-robin pick: a sole requester wins, a tie goes to the one not served last.
    function automatic logic pick_winner(input logic [1:0] req, input logic last_id);
        logic w;
        case (req)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            default: w = ~last_id;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/updown_step.sv
// Counter register with load and modulo-2^WIDTH up/down step; also exposes the
// value the next step would produce so the scheduler can detect the end value.
module updown_step
    import updown_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v, input logic d);
        return (d == DIR_UP) ? (v + ONE) : (v - ONE);
    endfunction

    assign nxt = step_val(q, dir);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/updown_cnt_sched.sv
// Round-robin scheduler sharing one bounded up/down counter between two
// requesters; each command loads a start value and steps to an end value.
module updown_cnt_sched
    import updown_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         req_dir,
    input  logic [2*WIDTH-1:0] req_start,
    input  logic [2*WIDTH-1:0] req_end,
    input  logic               abort,
    output logic [1:0]         gnt,
    output logic               busy,
    output logic [WIDTH-1:0]   cnt_q,
    output logic               cnt_dir,
    output logic               done,
    output logic               done_id,
    output logic               done_abort
);

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    state_t           state;
    logic [7:0]       ps_cnt;
    logic             last_id;
    logic             owner;
    logic             win;
    logic             lat_dir;
    logic [WIDTH-1:0] lat_start;
    logic [WIDTH-1:0] lat_end;
    logic [WIDTH-1:0] cnt_nxt;
    logic             do_load;
    logic             do_step;
    logic             accept;

    assign win     = pick_winner(req, last_id);
    assign accept  = (state == IDLE) && (req != 2'b00);
    assign do_load = (state == LOAD) && !abort;
    assign do_step = (state == RUN) && !abort && (ps_cnt == PS_LAST);

    updown_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (do_load),
        .load_val (lat_start),
        .step     (do_step),
        .dir      (cnt_dir),
        .q        (cnt_q),
        .nxt      (cnt_nxt)
    );

    // Command fields are pure data: captured at accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_dir   <= req_dir[win];
            lat_start <= win ? req_start[2*WIDTH-1:WIDTH] : req_start[WIDTH-1:0];
            lat_end   <= win ? req_end[2*WIDTH-1:WIDTH]   : req_end[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            done_abort <= 1'b0;
            cnt_dir    <= DIR_UP;
            ps_cnt     <= 8'd0;
            last_id    <= 1'b1;
            owner      <= 1'b0;
        end else begin
            gnt        <= 2'b00;
            done       <= 1'b0;
            done_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= win;
                        last_id <= win;
                        gnt     <= win ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        done_abort <= 1'b1;
                        done_id    <= owner;
                    end else begin
                        cnt_dir <= lat_dir;
                        ps_cnt  <= 8'd0;
                        if (lat_start == lat_end) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            done_id <= owner;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a coincident final step.
                    if (abort) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        done_abort <= 1'b1;
                        done_id    <= owner;
                    end else if (ps_cnt == PS_LAST) begin
                        ps_cnt <= 8'd0;
                        if (cnt_nxt == lat_end) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            done_id <= owner;
                        end
                    end else begin
                        ps_cnt <= ps_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
